// File: rtl/channel_accumulator.sv
// Sums `channel` PE partials plus per-kernel bias, requantizes (>>> shift, clamp) into a valid/ready output register.
// Build option: define CHANACC_RELU_EN for ReLU + unsigned clamp; otherwise a signed two's-complement clamp.
module channel_accumulator #(
    parameter int conv_result_bits = 16,
    parameter int channel          = 3,
    parameter int kernel_number    = 1,
    parameter int bias_bits        = 16,
    parameter int out_bits         = 8,
    parameter int shift            = 4,
    localparam int KW              = (kernel_number > 1) ? $clog2(kernel_number) : 1
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               clear,
    input  logic                               in_valid,
    input  logic [conv_result_bits-1:0]        in_data,
    input  logic signed [bias_bits-1:0]        bias [kernel_number-1:0],
    output logic                               out_valid,
    input  logic                               out_ready,
    output logic [out_bits-1:0]                out_data,
    output logic [KW-1:0]                      out_kernel_idx,
    output logic                               out_sat,
    output logic                               overflow
);

    localparam int SUM_W = conv_result_bits + $clog2(channel) + 1;
    localparam int ACC_W = ((SUM_W > bias_bits) ? SUM_W : bias_bits) + 1;
    localparam int CW    = (channel > 1) ? $clog2(channel) : 1;

    typedef logic signed [ACC_W-1:0] acc_t;

    localparam logic [CW-1:0] CH_LAST = CW'(channel - 1);
    localparam logic [KW-1:0] K_LAST  = KW'(kernel_number - 1);

`ifdef CHANACC_RELU_EN
    localparam acc_t Q_MAX = acc_t'((longint'(1) << out_bits) - 1);
    localparam acc_t Q_MIN = '0;
`else
    localparam acc_t Q_MAX = acc_t'((longint'(1) << (out_bits - 1)) - 1);
    localparam acc_t Q_MIN = acc_t'(-(longint'(1) << (out_bits - 1)));
`endif

    logic [CW-1:0]       chan_cnt_q, chan_cnt_d;
    logic [KW-1:0]       kern_cnt_q, kern_cnt_d;
    acc_t                acc_q, acc_d;
    logic                out_valid_q, out_valid_d;
    logic [out_bits-1:0] out_data_q, out_data_d;
    logic [KW-1:0]       out_idx_q, out_idx_d;
    logic                out_sat_q, out_sat_d;
    logic                overflow_q, overflow_d;

    acc_t                acc_base, acc_next, q;
    logic [out_bits-1:0] q_val;
    logic                q_sat;
    logic                last;

    always_comb begin
        acc_base = (chan_cnt_q == '0) ? acc_t'(bias[kern_cnt_q]) : acc_q;
        acc_next = acc_base + acc_t'({1'b0, in_data});
        q        = acc_next >>> shift;
        q_val    = q[out_bits-1:0];
        q_sat    = 1'b0;
        if (q > Q_MAX) begin
            q_val = Q_MAX[out_bits-1:0];
            q_sat = 1'b1;
        end else if (q < Q_MIN) begin
            q_val = Q_MIN[out_bits-1:0];
`ifndef CHANACC_RELU_EN
            q_sat = 1'b1;
`endif
        end
    end

    always_comb begin
        chan_cnt_d  = chan_cnt_q;
        kern_cnt_d  = kern_cnt_q;
        acc_d       = acc_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_idx_d   = out_idx_q;
        out_sat_d   = out_sat_q;
        overflow_d  = overflow_q;
        last        = in_valid && !clear && (chan_cnt_q == CH_LAST);

        if (clear) begin
            chan_cnt_d = '0;
            kern_cnt_d = '0;
        end else if (in_valid) begin
            acc_d      = acc_next;
            chan_cnt_d = last ? '0 : chan_cnt_q + 1'b1;
            if (last)
                kern_cnt_d = (kern_cnt_q == K_LAST) ? '0 : kern_cnt_q + 1'b1;
        end

        if (out_valid_q && out_ready)
            out_valid_d = 1'b0;
        // A completion lands in the register only if it is empty or draining this cycle.
        if (last) begin
            if (!out_valid_q || out_ready) begin
                out_valid_d = 1'b1;
                out_data_d  = q_val;
                out_idx_d   = kern_cnt_q;
                out_sat_d   = q_sat;
            end else begin
                overflow_d  = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            chan_cnt_q  <= '0;
            kern_cnt_q  <= '0;
            acc_q       <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_idx_q   <= '0;
            out_sat_q   <= 1'b0;
            overflow_q  <= 1'b0;
        end else begin
            chan_cnt_q  <= chan_cnt_d;
            kern_cnt_q  <= kern_cnt_d;
            acc_q       <= acc_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_idx_q   <= out_idx_d;
            out_sat_q   <= out_sat_d;
            overflow_q  <= overflow_d;
        end
    end

    assign out_valid      = out_valid_q;
    assign out_data       = out_data_q;
    assign out_kernel_idx = out_idx_q;
    assign out_sat        = out_sat_q;
    assign overflow       = overflow_q;

endmodule
